// File: rtl/multicycle_chunk_adder_pkg.sv
// Shared definitions for the multi-cycle chunked add/subtract unit:
// FSM state encodings and the chunk-counter width derivation.
package multicycle_chunk_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter width for nchunk chunks; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned nchunk);
        return (nchunk > 1) ? 32'($clog2(nchunk)) : 32'd1;
    endfunction

endpackage

// File: rtl/multicycle_chunk_adder_ripple.sv
// Combinational N-bit ripple-carry adder assembled from per-bit full-adder cells;
// serves as the per-cycle datapath of the chunked adder.
module chunk_ripple_adder #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         ci,
    output logic [N-1:0] sum_c,
    output logic         cout_c
);

    logic [N:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum_c[i] = x[i] ^ y[i] ^ c[i];
        assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout_c = c[N];

endmodule

// File: rtl/multicycle_chunk_adder.sv
// WIDTH-bit add/subtract unit that resolves CHUNK bits per clock through a
// registered carry, with valid/ready handshakes and registered ALU flags.
module multicycle_chunk_adder
    import multicycle_chunk_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = cnt_width(NCHUNK);

    state_e state_q, state_d;

    logic [NCHUNK-1:0][CHUNK-1:0] a_q, a_d;
    logic [NCHUNK-1:0][CHUNK-1:0] b_q, b_d;
    logic [NCHUNK-1:0][CHUNK-1:0] sum_q, sum_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         carry_q, carry_d;
    logic                         in_ready_q, in_ready_d;
    logic                         out_valid_q, out_valid_d;
    logic                         cout_q, cout_d;
    logic                         ovf_q, ovf_d;
    logic                         zero_q, zero_d;

    logic                         accept_c;
    logic                         last_c;
    logic                         release_c;
    logic [CHUNK-1:0]             chunk_sum_c;
    logic                         chunk_cout_c;

    assign accept_c  = in_valid && in_ready_q;
    assign last_c    = (cnt_q == CW'(NCHUNK - 1));
    assign release_c = out_valid_q && out_ready;

    chunk_ripple_adder #(.N(CHUNK)) u_chunk (
        .x      (a_q[cnt_q]),
        .y      (b_q[cnt_q]),
        .ci     (carry_q),
        .sum_c  (chunk_sum_c),
        .cout_c (chunk_cout_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c)  state_d = ST_BUSY;
            ST_BUSY: if (last_c)    state_d = ST_DONE;
            ST_DONE: if (release_c) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Next values of the operand, carry, result and handshake registers
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    a_d        = a;
                    b_d        = sub ? ~b : b;
                    carry_d    = sub | cin;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                end
            end
            ST_BUSY: begin
                sum_d[cnt_q] = chunk_sum_c;
                carry_d      = chunk_cout_c;
                cnt_d        = last_c ? '0 : cnt_q + CW'(1);
                // The last chunk carries the MSB, so the flags resolve on this edge
                if (last_c) begin
                    out_valid_d = 1'b1;
                    cout_d      = chunk_cout_c;
                    zero_d      = (sum_d == '0);
                    ovf_d       = (a_q[NCHUNK-1][CHUNK-1] == b_q[NCHUNK-1][CHUNK-1]) &&
                                  (chunk_sum_c[CHUNK-1] != a_q[NCHUNK-1][CHUNK-1]);
                end
            end
            ST_DONE: begin
                if (release_c) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
